// File: rtl/m6502_dma_arbiter.sv
// Shares one memory port between a 6502 CPU and a DMA engine.
// The CPU is stalled through RDY during DMA bursts, but its write cycles always win the bus.
module m6502_dma_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        res_n,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we_n,
   input  logic [7:0]  cpu_datao,
   output logic [7:0]  cpu_datai,
   output logic        cpu_rdy,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic        dma_we,
   input  logic [7:0]  dma_wdata,
   output logic        dma_gnt,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_we_n,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [15:0] stall_cnt
);

   localparam int unsigned BURST_W = 8;
   localparam int unsigned STALL_W = 16;
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
   localparam logic [BURST_W-1:0] BURST_MAX  = {BURST_W{1'b1}};
   localparam logic [STALL_W-1:0] STALL_MAX  = {STALL_W{1'b1}};

   typedef enum logic [1:0] {
      ST_CPU,
      ST_DMA,
      ST_HOLDOFF
   } state_t;

   state_t             state;
   logic [BURST_W-1:0] burst_cnt;

   // Bus steering: the memory follows the CPU except on DMA cycles without a CPU write.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_datao;
      mem_we_n  = cpu_we_n;
      cpu_rdy   = 1'b1;
      dma_gnt   = 1'b0;
      dma_ack   = 1'b0;
      if (state == ST_DMA) begin
         dma_gnt = 1'b1;
         cpu_rdy = 1'b0;
         if (cpu_we_n) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we_n  = ~(dma_we & dma_req);
            dma_ack   = dma_req;
         end
      end
   end

   assign cpu_datai = mem_rdata;
   assign dma_rdata = mem_rdata;

   // Grant FSM, burst length tracking and stall statistics.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state     <= ST_CPU;
         burst_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         case (state)
            ST_CPU: begin
               if (dma_req) begin
                  state     <= ST_DMA;
                  burst_cnt <= '0;
               end
            end
            ST_DMA: begin
               if (!dma_req || (dma_ack && (burst_cnt == BURST_LAST)))
                  state <= ST_HOLDOFF;
               if (dma_ack && (burst_cnt != BURST_MAX))
                  burst_cnt <= burst_cnt + BURST_W'(1);
            end
            ST_HOLDOFF: state <= ST_CPU;
            default:    state <= ST_CPU;
         endcase
         if (!cpu_rdy && (stall_cnt != STALL_MAX))
            stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_m6502_dma_arbiter.sv
// Directed bench for m6502_dma_arbiter with a behavioural 64 KiB memory
// (combinational read, write at posedge while reset is released).
module tb_m6502_dma_arbiter;

   logic        clk;
   logic        res_n;
   logic [15:0] cpu_addr;
   logic        cpu_we_n;
   logic [7:0]  cpu_datao;
   logic [7:0]  cpu_datai;
   logic        cpu_rdy;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic        dma_we;
   logic [7:0]  dma_wdata;
   logic        dma_gnt;
   logic        dma_ack;
   logic [7:0]  dma_rdata;
   logic [15:0] mem_addr;
   logic        mem_we_n;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [15:0] stall_cnt;

   logic [7:0]  mem [0:65535];

   int total = 0;
   int bad   = 0;

   m6502_dma_arbiter #(.MAX_BURST(4)) dut (
      .clk       (clk),
      .res_n     (res_n),
      .cpu_addr  (cpu_addr),
      .cpu_we_n  (cpu_we_n),
      .cpu_datao (cpu_datao),
      .cpu_datai (cpu_datai),
      .cpu_rdy   (cpu_rdy),
      .dma_req   (dma_req),
      .dma_addr  (dma_addr),
      .dma_we    (dma_we),
      .dma_wdata (dma_wdata),
      .dma_gnt   (dma_gnt),
      .dma_ack   (dma_ack),
      .dma_rdata (dma_rdata),
      .mem_addr  (mem_addr),
      .mem_we_n  (mem_we_n),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk)
      if (res_n && !mem_we_n) mem[mem_addr] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      res_n    = 1'b0;
      dma_req  = 1'b0;
      cpu_we_n = 1'b1;
      #1;
      chk("rst_stall", 32'(stall_cnt), 32'h0);
      chk("rst_gnt",   32'(dma_gnt),   32'h0);
      cyc();
      res_n = 1'b1;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      res_n     = 1'b0;
      cpu_addr  = 16'h1234;
      cpu_we_n  = 1'b1;
      cpu_datao = 8'h00;
      dma_req   = 1'b0;
      dma_addr  = 16'h0000;
      dma_we    = 1'b0;
      dma_wdata = 8'h00;
      #1;
      chk("rst_rdy",   32'(cpu_rdy),   32'h1);
      chk("rst_gnt0",  32'(dma_gnt),   32'h0);
      chk("rst_ack",   32'(dma_ack),   32'h0);
      chk("rst_stall0",32'(stall_cnt), 32'h0);
      chk("rst_maddr", 32'(mem_addr),  32'h1234);
      chk("rst_mwe",   32'(mem_we_n),  32'h1);
      cyc();
      res_n = 1'b1;

      // Idle: CPU owns the bus, nothing stalls
      for (int i = 0; i < 10; i++) begin
         cpu_addr = 16'h0100 + 16'(i);
         #1;
         chk("idle_rdy",   32'(cpu_rdy),  32'h1);
         chk("idle_maddr", 32'(mem_addr), 32'(16'h0100 + 16'(i)));
         cyc();
      end
      chk("idle_stall", 32'(stall_cnt), 32'h0);

      // CPU write preloads 8010=A5, then DMA read one cycle after request
      cpu_we_n = 1'b0; cpu_addr = 16'h8010; cpu_datao = 8'hA5;
      #1;
      chk("pre_mwe", 32'(mem_we_n), 32'h0);
      cyc();
      cpu_we_n = 1'b1; cpu_addr = 16'h0000;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h8010;
      #1;
      chk("rd_req_ack", 32'(dma_ack), 32'h0);
      chk("rd_req_gnt", 32'(dma_gnt), 32'h0);
      cyc();
      chk("rd_gnt",   32'(dma_gnt),   32'h1);
      chk("rd_ack",   32'(dma_ack),   32'h1);
      chk("rd_data",  32'(dma_rdata), 32'hA5);
      chk("rd_rdy",   32'(cpu_rdy),   32'h0);
      chk("rd_mwe",   32'(mem_we_n),  32'h1);
      chk("rd_maddr", 32'(mem_addr),  32'h8010);
      cyc();
      dma_req = 1'b0;
      #1;
      chk("drop_gnt", 32'(dma_gnt), 32'h1);
      chk("drop_ack", 32'(dma_ack), 32'h0);
      cyc();
      chk("ho_gnt", 32'(dma_gnt), 32'h0);
      chk("ho_rdy", 32'(cpu_rdy), 32'h1);
      dma_req = 1'b1;
      #1;
      chk("ho_ack", 32'(dma_ack), 32'h0);
      cyc();
      chk("ho_cpu_gnt", 32'(dma_gnt), 32'h0);
      chk("ho_cpu_ack", 32'(dma_ack), 32'h0);
      chk("ho_cpu_rdy", 32'(cpu_rdy), 32'h1);
      cyc();
      chk("regnt_gnt",   32'(dma_gnt),   32'h1);
      chk("regnt_ack",   32'(dma_ack),   32'h1);
      chk("regnt_data",  32'(dma_rdata), 32'hA5);
      chk("regnt_stall", 32'(stall_cnt), 32'h2);
      cyc();
      dma_req = 1'b0;
      cyc();
      chk("rd_end_stall", 32'(stall_cnt), 32'h4);
      cyc();

      // Eight queued writes with MAX_BURST=4: two bursts split by HOLDOFF + CPU
      do_reset();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h9000; dma_wdata = 8'h10;
      #1;
      chk("wr_cpu_ack", 32'(dma_ack), 32'h0);
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            cyc();
            chk("wr_ho_gnt", 32'(dma_gnt), 32'h0);
            chk("wr_ho_rdy", 32'(cpu_rdy), 32'h1);
            chk("wr_ho_ack", 32'(dma_ack), 32'h0);
            cyc();
            chk("wr_cpu_gnt", 32'(dma_gnt), 32'h0);
            chk("wr_cpu_ack2", 32'(dma_ack), 32'h0);
         end
         cyc();
         dma_addr  = 16'h9000 + 16'(k);
         dma_wdata = 8'h10 + 8'(k);
         #1;
         chk("wr_gnt",   32'(dma_gnt),  32'h1);
         chk("wr_ack",   32'(dma_ack),  32'h1);
         chk("wr_mwe",   32'(mem_we_n), 32'h0);
         chk("wr_maddr", 32'(mem_addr), 32'(16'h9000 + 16'(k)));
      end
      cyc();
      dma_req = 1'b0;
      chk("wr_end_gnt",   32'(dma_gnt),   32'h0);
      chk("wr_end_stall", 32'(stall_cnt), 32'h8);
      for (int k = 0; k < 8; k++)
         chk("wr_mem", 32'(mem[16'h9000 + 16'(k)]), 32'(8'h10 + 8'(k)));
      cyc();
      cpu_addr = 16'h9003;
      #1;
      chk("wr_cpu_rd", 32'(cpu_datai), 32'h13);

      // CPU write during the first DMA cycle wins, first ack slips a cycle
      do_reset();
      cpu_addr = 16'h0000;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hA000; dma_wdata = 8'h5A;
      cyc();
      cpu_we_n = 1'b0; cpu_addr = 16'hA100; cpu_datao = 8'hC3;
      #1;
      chk("ovr_gnt",   32'(dma_gnt),  32'h1);
      chk("ovr_ack",   32'(dma_ack),  32'h0);
      chk("ovr_rdy",   32'(cpu_rdy),  32'h0);
      chk("ovr_maddr", 32'(mem_addr), 32'hA100);
      chk("ovr_mwe",   32'(mem_we_n), 32'h0);
      cyc();
      cpu_we_n = 1'b1;
      #1;
      chk("ovr_ack2",   32'(dma_ack),  32'h1);
      chk("ovr_maddr2", 32'(mem_addr), 32'hA000);
      cyc();
      dma_req = 1'b0;
      chk("ovr_cpu_mem", 32'(mem[16'hA100]), 32'hC3);
      chk("ovr_dma_mem", 32'(mem[16'hA000]), 32'h5A);
      cyc();
      chk("ovr_stall", 32'(stall_cnt), 32'h3);
      chk("ovr_ho_gnt", 32'(dma_gnt), 32'h0);
      cyc();

      // Reset during the third transfer of a burst aborts it uncommitted
      do_reset();
      cpu_we_n = 1'b0; cpu_addr = 16'hB002; cpu_datao = 8'hEE;
      cyc();
      cpu_we_n = 1'b1; cpu_addr = 16'h0000;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hB000; dma_wdata = 8'h20;
      cyc();
      cyc();
      dma_addr = 16'hB001; dma_wdata = 8'h21;
      cyc();
      dma_addr = 16'hB002; dma_wdata = 8'h22;
      #1;
      chk("ab_ack_pre", 32'(dma_ack), 32'h1);
      res_n = 1'b0;
      #1;
      chk("ab_gnt",   32'(dma_gnt),   32'h0);
      chk("ab_rdy",   32'(cpu_rdy),   32'h1);
      chk("ab_ack",   32'(dma_ack),   32'h0);
      chk("ab_stall", 32'(stall_cnt), 32'h0);
      chk("ab_mwe",   32'(mem_we_n),  32'h1);
      cyc();
      dma_req = 1'b0;
      res_n = 1'b1;
      cyc();
      chk("ab_mem0",  32'(mem[16'hB000]), 32'h20);
      chk("ab_mem1",  32'(mem[16'hB001]), 32'h21);
      chk("ab_mem2",  32'(mem[16'hB002]), 32'hEE);
      chk("ab_post_gnt", 32'(dma_gnt), 32'h0);
      chk("ab_post_stall", 32'(stall_cnt), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
